// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM modem reply receive path.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package gsm_pkg;

    // Reply characters the matcher looks for
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_R  = 8'h52;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Clocks per bit period; integer division, caller guarantees result >= 4
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, start/data/stop FSM, byte output.
// Latency: rx_valid 2 + DIV/2 + 9*DIV clocks after the start-bit falling edge.
// Backpressure: none; rx_valid/frame_err are single-cycle pulses, consumer must keep up.
// Ports: clk, rst (sync, active high), rx (async line), rx_data/rx_valid/frame_err outputs.
module uart_rx_core
    import gsm_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int              CW       = $clog2(DIV);
    localparam logic [CW-1:0]   CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DIV - 1);

    logic            rx_m;
    logic            rx_s;
    rx_state_t       state,     state_nxt;
    logic [CW-1:0]   cnt,       cnt_nxt;
    logic [2:0]      bit_idx,   bit_nxt;
    logic [7:0]      shift,     shift_nxt;
    logic [7:0]      data_nxt;
    logic            vld_nxt;
    logic            ferr_nxt;
    // Set after a bad stop bit: the line may still be low, so ignore it
    // until it has been seen high again rather than treating it as a start.
    logic            hold_low,  hold_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            hold_low  <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= vld_nxt;
            frame_err <= ferr_nxt;
            hold_low  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        data_nxt  = rx_data;
        vld_nxt   = 1'b0;
        ferr_nxt  = 1'b0;
        hold_nxt  = hold_low;

        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    hold_nxt = 1'b0;
                end else if (!hold_low) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Mid-point of the start bit: a high line here was a glitch
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    if (rx_s) begin
                        data_nxt = shift;
                        vld_nxt  = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                        hold_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/gsm_resp_rx.sv
// GSM modem reply receiver: UART RX plus "OK"+CR+LF / "ERROR" matcher and response-window timer.
// Latency: result pulse one clock after the rx_valid of the completing byte; timeout TIMEOUT_CYCLES after arm.
// Backpressure: none; all outputs are single-cycle pulses except armed.
// Ports: clk, rst, rx, resp_arm in; rx_data, rx_valid, frame_err, resp_ok, resp_error, resp_timeout, armed out.
module gsm_resp_rx
    import gsm_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD           = 9600,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       resp_arm,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       resp_ok,
    output logic       resp_error,
    output logic       resp_timeout,
    output logic       armed
);

    localparam int              DIV     = calc_div(CLK_FREQ, BAUD);
    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     OK_PAT  = {CH_O, CH_K, CH_CR, CH_LF};
    localparam logic [39:0]     ERR_PAT = {CH_E, CH_R, CH_R, CH_O, CH_R};

    uart_rx_core #(
        .DIV (DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // Only the four previous bytes are stored; together with the byte
    // arriving this cycle they form the five-byte match window.
    logic [31:0]   hist;
    logic [39:0]   hist_new;
    logic [TW-1:0] timer;
    logic          ok_hit;
    logic          err_hit;

    always_comb begin
        hist_new = {hist, rx_data};
        ok_hit   = rx_valid && (hist_new[31:0] == OK_PAT);
        err_hit  = rx_valid && (hist_new == ERR_PAT);
    end

    // Priority: a new arm beats any result of the old window; a match beats
    // a timeout landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist         <= '0;
            timer        <= '0;
            armed        <= 1'b0;
            resp_ok      <= 1'b0;
            resp_error   <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            resp_ok      <= 1'b0;
            resp_error   <= 1'b0;
            resp_timeout <= 1'b0;
            if (resp_arm) begin
                armed <= 1'b1;
                hist  <= '0;
                timer <= '0;
            end else if (armed) begin
                if (rx_valid) begin
                    hist <= hist_new[31:0];
                end
                if (ok_hit) begin
                    resp_ok <= 1'b1;
                    armed   <= 1'b0;
                end else if (err_hit) begin
                    resp_error <= 1'b1;
                    armed      <= 1'b0;
                end else if (timer == T_LAST) begin
                    resp_timeout <= 1'b1;
                    armed        <= 1'b0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gsm_resp_rx.sv
// Testbench for gsm_resp_rx: vector table, directed window sequences, randomized windows vs. model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gsm_resp_rx;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int TOUT     = 2000;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       resp_arm;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       resp_ok;
    logic       resp_error;
    logic       resp_timeout;
    logic       armed;

    gsm_resp_rx #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .resp_arm     (resp_arm),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err),
        .resp_ok      (resp_ok),
        .resp_error   (resp_error),
        .resp_timeout (resp_timeout),
        .armed        (armed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         n_valid = 0, n_ferr = 0, n_ok = 0, n_err = 0, n_to = 0;
    int         valid_cyc = 0, ok_cyc = 0, err_cyc = 0, to_cyc = 0;
    logic       to_armed = 1'b0, to_prev_armed = 1'b0, prev_armed = 1'b0;
    logic [7:0] mon_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rx_valid)   begin n_valid++; valid_cyc = cyc; mon_q.push_back(rx_data); end
        if (frame_err)  n_ferr++;
        if (resp_ok)    begin n_ok++;  ok_cyc  = cyc; end
        if (resp_error) begin n_err++; err_cyc = cyc; end
        if (resp_timeout) begin
            n_to++;
            to_cyc        = cyc;
            to_armed      = armed;
            to_prev_armed = prev_armed;
        end
        prev_armed = armed;
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- drivers ----------------
    int fall_cyc = 0;
    int arm_cyc  = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        fall_cyc = cyc;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
        rx = 1'b1;
        tick(3 * DIV);
    endtask

    task automatic arm();
        resp_arm = 1'b1;
        arm_cyc  = cyc + 1;
        tick(1);
        resp_arm = 1'b0;
    endtask

    task automatic wait_window_end();
        while (cyc < arm_cyc + TOUT + 100) tick(1);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] pat_ok[$]  = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    logic [7:0] pat_err[$] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52};

    function automatic bit tail_is(input logic [7:0] q[$], input logic [7:0] pat[$]);
        if (q.size() < pat.size()) return 1'b0;
        for (int i = 0; i < pat.size(); i++)
            if (q[q.size() - pat.size() + i] != pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] dat;
        logic       stop;
        int         exp_vld;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[7];

    logic [7:0] seq1[4]  = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    logic [7:0] seq2[11] = '{8'h41, 8'h54, 8'h0D, 8'h0A, 8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};
    logic [7:0] alpha[8] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A, 8'h45, 8'h52, 8'h41, 8'h54};

    int         v0, f0, o0, e0, t0, d, save_cyc, nb, p1, p2, kind, e_ok, e_err, e_to, mism;
    bit         m_arm;
    logic [7:0] wb[8];
    logic [7:0] h[$];

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[2] = '{8'h4F, 1'b1, 1, 0, 8'h4F};
        vecs[3] = '{8'h55, 1'b0, 0, 1, 8'h4F};   // bad stop: data kept
        vecs[4] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};
        vecs[6] = '{8'h01, 1'b1, 1, 0, 8'h01};

        rst = 1'b1; rx = 1'b1; resp_arm = 1'b0;
        tick(3);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset resp_ok", resp_ok, 0);
        check("reset resp_error", resp_error, 0);
        check("reset resp_timeout", resp_timeout, 0);
        check("reset armed", armed, 0);
        rst = 1'b0;
        tick(5);

        // Table: unarmed single bytes, including a framing error
        for (int i = 0; i < 7; i++) begin
            v0 = n_valid; f0 = n_ferr;
            send_byte(vecs[i].dat, vecs[i].stop);
            check($sformatf("vec%0d rx_valid count", i), n_valid - v0, vecs[i].exp_vld);
            check($sformatf("vec%0d frame_err count", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
        end

        // 1: OK reply
        mon_q.delete(); o0 = n_ok; t0 = n_to;
        arm();
        check("t1 armed after arm", armed, 1);
        for (int i = 0; i < 4; i++) begin
            send_byte(seq1[i], 1'b1);
            if (i == 0) begin
                d = valid_cyc - fall_cyc - 1;
                check("t1 rx latency within 97+-1", (d >= 96 && d <= 98), 1);
            end
        end
        check("t1 rx_valid count", mon_q.size(), 4);
        mism = 0;
        for (int i = 0; i < 4 && i < mon_q.size(); i++) if (mon_q[i] != seq1[i]) mism++;
        check("t1 rx_data bytes", mism, 0);
        check("t1 resp_ok count", n_ok - o0, 1);
        check("t1 resp_ok cycle after rx_valid", ok_cyc - valid_cyc, 1);
        check("t1 armed cleared", armed, 0);
        wait_window_end();
        check("t1 no timeout", n_to - t0, 0);

        // 2: ERROR reply embedded in echo, trailing CRLF
        mon_q.delete(); o0 = n_ok; e0 = n_err; t0 = n_to;
        arm();
        save_cyc = 0;
        for (int i = 0; i < 11; i++) begin
            send_byte(seq2[i], 1'b1);
            if (i == 8) save_cyc = valid_cyc;
        end
        check("t2 rx_valid count", mon_q.size(), 11);
        check("t2 resp_error count", n_err - e0, 1);
        check("t2 resp_error cycle", err_cyc - save_cyc, 1);
        check("t2 resp_ok count", n_ok - o0, 0);
        wait_window_end();
        check("t2 no timeout", n_to - t0, 0);

        // 3: silent window
        t0 = n_to;
        arm();
        wait_window_end();
        check("t3 timeout count", n_to - t0, 1);
        check("t3 timeout delay", to_cyc - arm_cyc, TOUT);
        check("t3 armed low with timeout", to_armed, 0);
        check("t3 armed high before timeout", to_prev_armed, 1);

        // 5: start glitch
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0; tick(3); rx = 1'b1; tick(10 * DIV);
        check("t5 glitch rx_valid", n_valid - v0, 0);
        check("t5 glitch frame_err", n_ferr - f0, 0);
        send_byte(8'h3C, 1'b1);
        check("t5 byte after glitch count", n_valid - v0, 1);
        check("t5 byte after glitch data", rx_data, 8'h3C);

        // 6: partial OK before arm, rest after
        o0 = n_ok; t0 = n_to;
        send_byte(8'h4F, 1'b1);
        send_byte(8'h4B, 1'b1);
        arm();
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        wait_window_end();
        check("t6 no resp_ok", n_ok - o0, 0);
        check("t6 timeout count", n_to - t0, 1);
        check("t6 timeout delay", to_cyc - arm_cyc, TOUT);

        // 6b: reset in the middle of a frame while armed
        arm();
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0; tick(4 * DIV);
        rst = 1'b1; rx = 1'b1;
        tick(1);
        check("rst rx_data", rx_data, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst frame_err", frame_err, 0);
        check("rst armed", armed, 0);
        check("rst resp_timeout", resp_timeout, 0);
        rst = 1'b0;
        tick(15 * DIV);
        check("rst no rx_valid", n_valid - v0, 0);
        check("rst no frame_err", n_ferr - f0, 0);
        send_byte(8'h96, 1'b1);
        check("rst next byte data", rx_data, 8'h96);

        // Randomized windows vs. model
        for (int w = 0; w < 10; w++) begin
            nb   = $urandom_range(1, 7);
            p1   = $urandom_range(0, nb - 1);
            p2   = ($urandom_range(0, 2) == 0 && p1 < nb - 1) ? $urandom_range(p1 + 1, nb - 1) : -1;
            kind = $urandom_range(0, 3);
            for (int i = 0; i < nb; i++) wb[i] = alpha[$urandom_range(0, 7)];
            if (kind == 0 && nb >= 4) for (int i = 0; i < 4; i++) wb[nb - 4 + i] = pat_ok[i];
            if (kind == 1 && nb >= 5) for (int i = 0; i < 5; i++) wb[nb - 5 + i] = pat_err[i];

            m_arm = 1'b0; h.delete(); e_ok = 0; e_err = 0; e_to = 0;
            for (int i = 0; i < nb; i++) begin
                if (i == p1 || i == p2) begin m_arm = 1'b1; h.delete(); end
                if (m_arm) begin
                    h.push_back(wb[i]);
                    if (tail_is(h, pat_ok))       begin e_ok++;  m_arm = 1'b0; end
                    else if (tail_is(h, pat_err)) begin e_err++; m_arm = 1'b0; end
                end
            end
            if (m_arm) e_to = 1;

            mon_q.delete(); o0 = n_ok; e0 = n_err; t0 = n_to;
            for (int i = 0; i < nb; i++) begin
                if (i == p1 || i == p2) arm();
                send_byte(wb[i], 1'b1);
            end
            wait_window_end();
            mism = (mon_q.size() != nb) ? 1 : 0;
            for (int i = 0; i < nb && i < mon_q.size(); i++) if (mon_q[i] != wb[i]) mism++;
            check($sformatf("rand%0d bytes", w), mism, 0);
            check($sformatf("rand%0d resp_ok", w), n_ok - o0, e_ok);
            check($sformatf("rand%0d resp_error", w), n_err - e0, e_err);
            check($sformatf("rand%0d resp_timeout", w), n_to - t0, e_to);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
